pc_unit: RTL and testbench

Parametrised program-counter unit for the IF stage. It holds the registered instruction address and selects the next address from five sources: sequential, PC-relative branch, absolute jump, call and return. Calls and returns use an internal return-address stack (RAS). A halt state machine and a stall input are included. Its output drives instruction-memory addressing; the redirect inputs come from ID/EX decode.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/ret_addr_stack.sv | 57 +++++
 rtl/pc_unit.sv | 118 +++++++++++
 tb/tb_pc_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared state and next-PC source encodings for the IF-stage PC unit.
// Rev 1.0
`default_nettype none

package pc_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pc_state_t;

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_SEQ  = 3'd1,
    SEL_BR   = 3'd2,
    SEL_JMP  = 3'd3,
    SEL_CALL = 3'd4,
    SEL_RET  = 3'd5
  } pc_sel_t;

endpackage

`default_nettype wire

// File: rtl/ret_addr_stack.sv
// ret_addr_stack: circular return-address stack; a push when full overwrites the oldest entry.
// Rev 1.0
`default_nettype none

module ret_addr_stack #(
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  // wr_ptr always names the next free slot; when full that slot holds the oldest entry.
  assign top   = mem[wr_ptr - PTR_ONE];
  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
      if (!full) begin
        count <= count + CNT_ONE;
      end
    end else if (pop && !empty) begin
      wr_ptr <= wr_ptr - PTR_ONE;
      count  <= count - CNT_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// pc_unit: registered instruction address with prioritised redirects, return-address stack and halt FSM.
// Rev 1.0
`default_nettype none

module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              hlt,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic              jmp,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] tgt,
  output logic [ADDR_W-1:0] iaddr,
  output logic              halted,
  output logic              ras_err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  pc_state_t         state, state_next;
  pc_sel_t           sel;
  logic [ADDR_W-1:0] seq_addr, br_addr, next_addr;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty, ras_full;
  logic              ras_push, ras_pop, err_next;

  assign seq_addr = iaddr + ADDR_ONE;
  assign br_addr  = seq_addr + br_offset;

  always_comb begin
    sel = SEL_SEQ;
    if (state == HALTED || hlt || stall) begin
      sel = SEL_HOLD;
    end else if (ret) begin
      sel = SEL_RET;
    end else if (call) begin
      sel = SEL_CALL;
    end else if (jmp) begin
      sel = SEL_JMP;
    end else if (br_taken) begin
      sel = SEL_BR;
    end
  end

  always_comb begin
    state_next = state;
    if (state == RUN && hlt) begin
      state_next = HALTED;
    end
  end

  // A ret on an empty stack holds the PC rather than jumping to stale data.
  always_comb begin
    next_addr = iaddr;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    err_next  = 1'b0;
    case (sel)
      SEL_SEQ:  next_addr = seq_addr;
      SEL_BR:   next_addr = br_addr;
      SEL_JMP:  next_addr = tgt;
      SEL_CALL: begin
        next_addr = tgt;
        ras_push  = 1'b1;
        err_next  = ras_full;
      end
      SEL_RET: begin
        if (ras_empty) begin
          err_next = 1'b1;
        end else begin
          next_addr = ras_top;
          ras_pop   = 1'b1;
        end
      end
      default: next_addr = iaddr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      iaddr   <= RESET_ADDR;
      ras_err <= 1'b0;
    end else begin
      state   <= state_next;
      iaddr   <= next_addr;
      ras_err <= err_next;
    end
  end

  assign halted = (state == HALTED);

  ret_addr_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit (ADDR_W=16, RESET_ADDR=0, RAS_DEPTH=4).
// Rev 1.0
`default_nettype none

module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, hlt, br_taken, jmp, call, ret;
  logic [15:0] br_offset, tgt;
  logic [15:0] iaddr;
  logic        halted, ras_err;

  int passed = 0;
  int total  = 0;

  pc_unit #(
    .ADDR_W     (16),
    .RESET_ADDR (16'h0000),
    .RAS_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .hlt       (hlt),
    .br_taken  (br_taken),
    .br_offset (br_offset),
    .jmp       (jmp),
    .call      (call),
    .ret       (ret),
    .tgt       (tgt),
    .iaddr     (iaddr),
    .halted    (halted),
    .ras_err   (ras_err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    stall = 0; hlt = 0; br_taken = 0; jmp = 0; call = 0; ret = 0;
    br_offset = 16'h0000; tgt = 16'h0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #3;
    total++; if (iaddr !== 16'h0000) $display("FAIL reset_iaddr got=%h exp=%h", iaddr, 16'h0000); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", halted); else passed++;
    total++; if (ras_err !== 1'b0) $display("FAIL reset_ras_err got=%b exp=0", ras_err); else passed++;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (iaddr !== 16'(i)) $display("FAIL freerun_%0d got=%h exp=%h", i, iaddr, 16'(i)); else passed++;
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (iaddr !== 16'h0000) $display("FAIL async_reset got=%h exp=%h", iaddr, 16'h0000); else passed++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_branch();
    jmp = 1; tgt = 16'h0010; tick(); jmp = 0;
    total++; if (iaddr !== 16'h0010) $display("FAIL jmp_0010 got=%h exp=%h", iaddr, 16'h0010); else passed++;
    br_taken = 1; br_offset = 16'hFFFC; tick();
    total++; if (iaddr !== 16'h000D) $display("FAIL br_back got=%h exp=%h", iaddr, 16'h000D); else passed++;
    br_offset = 16'h7FFF; tick(); br_taken = 0;
    total++; if (iaddr !== 16'h800D) $display("FAIL br_fwd got=%h exp=%h", iaddr, 16'h800D); else passed++;
    jmp = 1; tgt = 16'hFFF0; tick(); jmp = 0;
    br_taken = 1; br_offset = 16'h0020; tick(); br_taken = 0;
    total++; if (iaddr !== 16'h0011) $display("FAIL br_wrap got=%h exp=%h", iaddr, 16'h0011); else passed++;
    jmp = 1; tgt = 16'hFFFF; tick(); jmp = 0;
    total++; if (iaddr !== 16'hFFFF) $display("FAIL jmp_ffff got=%h exp=%h", iaddr, 16'hFFFF); else passed++;
    tick();
    total++; if (iaddr !== 16'h0000) $display("FAIL seq_wrap got=%h exp=%h", iaddr, 16'h0000); else passed++;
  endtask

  task automatic test_call_ret();
    jmp = 1; tgt = 16'h0005; tick(); jmp = 0;
    call = 1; tgt = 16'h0100; tick(); call = 0;
    total++; if (iaddr !== 16'h0100) $display("FAIL call_tgt got=%h exp=%h", iaddr, 16'h0100); else passed++;
    tick();
    total++; if (iaddr !== 16'h0101) $display("FAIL call_seq got=%h exp=%h", iaddr, 16'h0101); else passed++;
    ret = 1; tick(); ret = 0;
    total++; if (iaddr !== 16'h0006) $display("FAIL ret_addr got=%h exp=%h", iaddr, 16'h0006); else passed++;
  endtask

  task automatic test_back_to_back();
    call = 1; tgt = 16'h0040; tick(); call = 0;
    total++; if (iaddr !== 16'h0040) $display("FAIL b2b_call got=%h exp=%h", iaddr, 16'h0040); else passed++;
    ret = 1; tick(); ret = 0;
    total++; if (iaddr !== 16'h0007) $display("FAIL b2b_ret got=%h exp=%h", iaddr, 16'h0007); else passed++;
    total++; if (ras_err !== 1'b0) $display("FAIL b2b_err got=%b exp=0", ras_err); else passed++;
  endtask

  task automatic test_overflow();
    // Starting at 0x0007 the pushes are 0x0008, 0x0101, 0x0201, 0x0301, 0x0401.
    for (int i = 1; i <= 5; i++) begin
      call = 1; tgt = 16'(i << 8); tick();
      total++; if (iaddr !== 16'(i << 8)) $display("FAIL ovf_call%0d got=%h exp=%h", i, iaddr, 16'(i << 8)); else passed++;
      total++; if (ras_err !== (i == 5)) $display("FAIL ovf_err%0d got=%b exp=%b", i, ras_err, (i == 5)); else passed++;
    end
    call = 0; ret = 1;
    for (int j = 4; j >= 1; j--) begin
      tick();
      total++; if (iaddr !== 16'((j << 8) + 1)) $display("FAIL pop%0d got=%h exp=%h", j, iaddr, 16'((j << 8) + 1)); else passed++;
      total++; if (ras_err !== 1'b0) $display("FAIL pop_err%0d got=%b exp=0", j, ras_err); else passed++;
    end
    tick(); ret = 0;
    total++; if (iaddr !== 16'h0101) $display("FAIL underflow_hold got=%h exp=%h", iaddr, 16'h0101); else passed++;
    total++; if (ras_err !== 1'b1) $display("FAIL underflow_err got=%b exp=1", ras_err); else passed++;
    tick();
    total++; if (iaddr !== 16'h0102) $display("FAIL post_uf got=%h exp=%h", iaddr, 16'h0102); else passed++;
    total++; if (ras_err !== 1'b0) $display("FAIL err_one_cycle got=%b exp=0", ras_err); else passed++;
  endtask

  task automatic test_stall();
    call = 1; tgt = 16'h0600; tick();
    stall = 1; jmp = 1; tgt = 16'h0700;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (iaddr !== 16'h0600) $display("FAIL stall_iaddr%0d got=%h exp=%h", i, iaddr, 16'h0600); else passed++;
      total++; if (ras_err !== 1'b0) $display("FAIL stall_err%0d got=%b exp=0", i, ras_err); else passed++;
    end
    clear_inputs();
    ret = 1; tick();
    total++; if (iaddr !== 16'h0103) $display("FAIL stall_ret got=%h exp=%h", iaddr, 16'h0103); else passed++;
    tick(); ret = 0;
    total++; if (ras_err !== 1'b1) $display("FAIL stall_count got=%b exp=1", ras_err); else passed++;
    total++; if (iaddr !== 16'h0103) $display("FAIL stall_uf_hold got=%h exp=%h", iaddr, 16'h0103); else passed++;
  endtask

  task automatic test_priority();
    call = 1; jmp = 1; br_taken = 1; br_offset = 16'h0005; tgt = 16'h0030; tick();
    total++; if (iaddr !== 16'h0030) $display("FAIL prio_call got=%h exp=%h", iaddr, 16'h0030); else passed++;
    call = 0; tgt = 16'h0050; tick();
    total++; if (iaddr !== 16'h0050) $display("FAIL prio_jmp got=%h exp=%h", iaddr, 16'h0050); else passed++;
    jmp = 0; ret = 1; call = 1; tick();
    total++; if (iaddr !== 16'h0104) $display("FAIL prio_ret got=%h exp=%h", iaddr, 16'h0104); else passed++;
    tick();
    total++; if (iaddr !== 16'h0104) $display("FAIL prio_uf_hold got=%h exp=%h", iaddr, 16'h0104); else passed++;
    total++; if (ras_err !== 1'b1) $display("FAIL prio_uf_err got=%b exp=1", ras_err); else passed++;
    clear_inputs(); tick();
    total++; if (iaddr !== 16'h0105) $display("FAIL prio_no_push got=%h exp=%h", iaddr, 16'h0105); else passed++;
  endtask

  task automatic test_halt();
    jmp = 1; tgt = 16'h0020; tick(); jmp = 0;
    hlt = 1; ret = 1; tick(); hlt = 0; ret = 0;
    total++; if (halted !== 1'b1) $display("FAIL halt_rise got=%b exp=1", halted); else passed++;
    total++; if (iaddr !== 16'h0020) $display("FAIL halt_iaddr got=%h exp=%h", iaddr, 16'h0020); else passed++;
    total++; if (ras_err !== 1'b0) $display("FAIL halt_err got=%b exp=0", ras_err); else passed++;
    jmp = 1; tgt = 16'h0099;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (iaddr !== 16'h0020 || halted !== 1'b1)
        $display("FAIL halt_freeze%0d got=%h/%b exp=%h/1", i, iaddr, halted, 16'h0020); else passed++;
    end
    jmp = 0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (halted !== 1'b0 || iaddr !== 16'h0000)
      $display("FAIL halt_reset got=%h/%b exp=%h/0", iaddr, halted, 16'h0000); else passed++;
    tick(); rst_n = 1'b1;
    tick();
    total++; if (iaddr !== 16'h0001) $display("FAIL halt_restart got=%h exp=%h", iaddr, 16'h0001); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_branch();
    test_call_ret();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_priority();
    test_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
